// File: rtl/udp_rx_gmii_if.sv
// GMII receive bus plus payload FIFO write port and frame status for udp_rx_gmii.
`timescale 1ns/1ps
interface udp_rx_gmii_if;
    logic        rxdv;
    logic        rxer;
    logic [7:0]  datain;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  dataout;
    logic [15:0] rx_data_length;
    logic        frame_ok;
    logic        frame_err;
    logic [3:0]  rx_state;

    modport master (
        output rxdv, rxer, datain, fifo_full,
        input  fifo_wr_en, dataout, rx_data_length, frame_ok, frame_err, rx_state
    );

    modport slave (
        input  rxdv, rxer, datain, fifo_full,
        output fifo_wr_en, dataout, rx_data_length, frame_ok, frame_err, rx_state
    );
endinterface

// File: rtl/udp_rx_gmii.sv
// GMII Ethernet/IPv4/UDP receive parser: filters on MAC/IP/port, streams the UDP payload to a FIFO
// and reports FCS/status per frame. Define RX_IP_CSUM_CHECK_EN to also verify the IPv4 header checksum.
`timescale 1ns/1ps
module udp_rx_gmii #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
    parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
    input logic          clk,
    input logic          rst,
    udp_rx_gmii_if.slave bus
);
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREAMBLE = 4'd1,
        S_MAC      = 4'd2,
        S_IPHDR    = 4'd3,
        S_UDPHDR   = 4'd4,
        S_DATA     = 4'd5,
        S_WAITEND  = 4'd6,
        S_DROP     = 4'd7
    } state_t;

    state_t           state, state_n;
    logic             armed, armed_n;
    logic             err, err_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      crc, crc_n;
    logic [7:0]       prev;
    logic             uni_ok, uni_ok_n, bc_ok, bc_ok_n;
    logic [15:0]      pay_len, pay_len_n;
    logic             wr_q, wr_n;
    logic [7:0]       dout_q, dout_n;
    logic [15:0]      len_q, len_n;
    logic             ok_q, ok_n, ferr_q, ferr_n;
    logic             in_frame;
    logic [15:0]      word;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return LOCAL_MAC[47:40];
            3'd1:    return LOCAL_MAC[39:32];
            3'd2:    return LOCAL_MAC[31:24];
            3'd3:    return LOCAL_MAC[23:16];
            3'd4:    return LOCAL_MAC[15:8];
            default: return LOCAL_MAC[7:0];
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return LOCAL_IP[31:24];
            2'd1:    return LOCAL_IP[23:16];
            2'd2:    return LOCAL_IP[15:8];
            default: return LOCAL_IP[7:0];
        endcase
    endfunction

    assign in_frame = (state == S_MAC) || (state == S_IPHDR) || (state == S_UDPHDR) ||
                      (state == S_DATA) || (state == S_WAITEND);
    assign word     = {prev, bus.datain};

`ifdef RX_IP_CSUM_CHECK_EN
    logic [15:0] csum, csum_n, csum_add;
    logic [16:0] csum_sum;
    // One's-complement accumulate with end-around carry
    assign csum_sum = {1'b0, csum} + {1'b0, word};
    assign csum_add = csum_sum[15:0] + 16'(csum_sum[16]);
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        armed_n   = armed | ~bus.rxdv;
        err_n     = err;
        cnt_n     = cnt;
        crc_n     = crc;
        uni_ok_n  = uni_ok;
        bc_ok_n   = bc_ok;
        pay_len_n = pay_len;
        wr_n      = 1'b0;
        dout_n    = dout_q;
        len_n     = len_q;
        ok_n      = 1'b0;
        ferr_n    = 1'b0;
`ifdef RX_IP_CSUM_CHECK_EN
        csum_n    = csum;
`endif
        if (in_frame && bus.rxdv) begin
            crc_n = crc_next(crc, bus.datain);
            if (bus.rxer) err_n = 1'b1;
        end

        if (in_frame && !bus.rxdv) begin
            state_n = S_IDLE;
            if (crc == CRC_RESIDUE && !err && state == S_WAITEND) ok_n = 1'b1;
            else ferr_n = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (armed && bus.rxdv)
                        state_n = (bus.datain == 8'h55) ? S_PREAMBLE : S_DROP;
                end
                S_PREAMBLE: begin
                    if (!bus.rxdv) state_n = S_IDLE;
                    else if (bus.datain == 8'hD5) begin
                        state_n  = S_MAC;
                        crc_n    = 32'hFFFFFFFF;
                        cnt_n    = '0;
                        err_n    = 1'b0;
                        uni_ok_n = 1'b1;
                        bc_ok_n  = 1'b1;
                    end else if (bus.datain != 8'h55) state_n = S_DROP;
                end
                S_MAC: begin
                    cnt_n = cnt + 16'd1;
                    if (cnt < 16'd6) begin
                        uni_ok_n = uni_ok & (bus.datain == mac_byte(cnt[2:0]));
                        bc_ok_n  = bc_ok & (bus.datain == 8'hFF);
                        if (!uni_ok_n && !bc_ok_n) state_n = S_DROP;
                    end else if (cnt == 16'd12 && bus.datain != 8'h08) state_n = S_DROP;
                    else if (cnt == 16'd13) begin
                        cnt_n   = '0;
                        state_n = (bus.datain == 8'h00) ? S_IPHDR : S_DROP;
`ifdef RX_IP_CSUM_CHECK_EN
                        csum_n  = '0;
`endif
                    end
                end
                S_IPHDR: begin
                    cnt_n = cnt + 16'd1;
`ifdef RX_IP_CSUM_CHECK_EN
                    if (cnt[0]) csum_n = csum_add;
`endif
                    if ((cnt == 16'd0 && bus.datain != 8'h45) ||
                        (cnt == 16'd9 && bus.datain != 8'h11) ||
                        (cnt >= 16'd16 && bus.datain != ip_byte(cnt[1:0])))
                        state_n = S_DROP;
`ifdef RX_IP_CSUM_CHECK_EN
                    else if (cnt == 16'd19 && csum_add != 16'hFFFF)
                        state_n = S_DROP;
`endif
                    else if (cnt == 16'd19) begin
                        state_n = S_UDPHDR;
                        cnt_n   = '0;
                    end
                end
                S_UDPHDR: begin
                    cnt_n = cnt + 16'd1;
                    if (cnt == 16'd3 && word != LOCAL_PORT) state_n = S_DROP;
                    else if (cnt == 16'd5) begin
                        if (word < 16'd8) state_n = S_DROP;
                        else pay_len_n = word - 16'd8;
                    end else if (cnt == 16'd7) begin
                        len_n   = pay_len;
                        cnt_n   = '0;
                        state_n = (pay_len == 16'd0) ? S_WAITEND : S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.fifo_full) begin
                        err_n   = 1'b1;
                        state_n = S_WAITEND;
                    end else begin
                        wr_n   = 1'b1;
                        dout_n = bus.datain;
                        cnt_n  = cnt + 16'd1;
                        if (cnt + 16'd1 == pay_len) state_n = S_WAITEND;
                    end
                end
                S_WAITEND: ;
                S_DROP: if (!bus.rxdv) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            armed   <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            crc     <= 32'hFFFFFFFF;
            prev    <= '0;
            uni_ok  <= 1'b0;
            bc_ok   <= 1'b0;
            pay_len <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            len_q   <= '0;
            ok_q    <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RX_IP_CSUM_CHECK_EN
            csum    <= '0;
`endif
        end else begin
            state   <= state_n;
            armed   <= armed_n;
            err     <= err_n;
            cnt     <= cnt_n;
            crc     <= crc_n;
            prev    <= bus.datain;
            uni_ok  <= uni_ok_n;
            bc_ok   <= bc_ok_n;
            pay_len <= pay_len_n;
            wr_q    <= wr_n;
            dout_q  <= dout_n;
            len_q   <= len_n;
            ok_q    <= ok_n;
            ferr_q  <= ferr_n;
`ifdef RX_IP_CSUM_CHECK_EN
            csum    <= csum_n;
`endif
        end
    end

    assign bus.fifo_wr_en     = wr_q;
    assign bus.dataout        = dout_q;
    assign bus.rx_data_length = len_q;
    assign bus.frame_ok       = ok_q;
    assign bus.frame_err      = ferr_q;
    assign bus.rx_state       = state;
endmodule

// File: tb/tb_udp_rx_gmii.sv
// Directed bench for udp_rx_gmii: builds complete frames with real IP checksum and FCS, checks writes and status.
`timescale 1ns/1ps
module tb_udp_rx_gmii;
    localparam logic [47:0] MAC_OK   = 48'h000A3501FEC0;
    localparam logic [47:0] MAC_BC   = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] IP_OK    = 32'hC0A80002;
    localparam logic [31:0] IP_BAD   = 32'hC0A80009;
    localparam int          PAY_IDX  = 42;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    udp_rx_gmii_if bus();
    udp_rx_gmii dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [7:0] frm[$];
    logic [7:0] pay[$];
    int wr_cnt = 0, ok_cnt = 0, err_cnt = 0, bad_cnt = 0, wr_base = 0;
    int w0, o0, e0, b0, w_all;
    logic [3:0] last_state;
    logic ok_now, err_now, ok_at_start;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: counts writes/pulses, compares written bytes against the expected payload
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) begin
            if ((wr_cnt - wr_base) >= pay.size() || bus.dataout !== pay[wr_cnt - wr_base]) bad_cnt++;
            wr_cnt++;
        end
        if (bus.frame_ok === 1'b1) ok_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    function automatic logic [31:0] fcs_of_frame();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (frm[i])
            for (int k = 0; k < 8; k++)
                if (c[0] ^ frm[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [31:0] dip,
                         input logic [15:0] ulen, input int npad, input logic csum_bad,
                         input logic [7:0] seed, input int flip_at);
        logic [7:0]  ip [20];
        logic [15:0] tot;
        logic [31:0] s;
        logic [15:0] cs;
        logic [31:0] f;
        logic [47:0] smac;
        frm.delete();
        pay.delete();
        smac = 48'h000A3501FEC1;
        for (int k = 0; k < 6; k++) frm.push_back(dmac[47 - 8*k -: 8]);
        for (int k = 0; k < 6; k++) frm.push_back(smac[47 - 8*k -: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        tot = 16'd20 + ulen;
        ip = '{8'h45, 8'h00, tot[15:8], tot[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h03,
               dip[31:24], dip[23:16], dip[15:8], dip[7:0]};
        s = 0;
        for (int k = 0; k < 10; k++) s = s + {16'h0, ip[2*k], ip[2*k+1]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        cs = ~s[15:0];
        if (csum_bad) cs = cs ^ 16'h0100;
        ip[10] = cs[15:8];
        ip[11] = cs[7:0];
        for (int k = 0; k < 20; k++) frm.push_back(ip[k]);
        frm.push_back(8'h1F); frm.push_back(8'h90);
        frm.push_back(8'h1F); frm.push_back(8'h90);
        frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int k = 0; k < int'(ulen) - 8; k++) begin
            pay.push_back(8'(k * 7) ^ seed);
            frm.push_back(8'(k * 7) ^ seed);
        end
        for (int k = 0; k < npad; k++) frm.push_back(8'h00);
        f = fcs_of_frame();
        frm.push_back(f[7:0]); frm.push_back(f[15:8]);
        frm.push_back(f[23:16]); frm.push_back(f[31:24]);
        if (flip_at >= 0) begin
            frm[PAY_IDX + flip_at] = frm[PAY_IDX + flip_at] ^ 8'h10;
            pay[flip_at] = pay[flip_at] ^ 8'h10;
        end
    endtask

    task automatic mark();
        wr_base = wr_cnt;
        w0 = wr_cnt; o0 = ok_cnt; e0 = err_cnt; b0 = bad_cnt;
    endtask

    task automatic send(input int full_at, input int rst_at, input int cut_at, input int er_at);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.rxdv = 1'b1;
            bus.datain = (k == 7) ? 8'hD5 : 8'h55;
            if (k == 0) ok_at_start = bus.frame_ok;
        end
        for (int i = 0; i < frm.size(); i++) begin
            if (i == cut_at) break;
            @(posedge clk); #1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                check_eq("rst_wr_en", 32'(bus.fifo_wr_en), 0);
                check_eq("rst_dataout", 32'(bus.dataout), 0);
                check_eq("rst_len", 32'(bus.rx_data_length), 0);
                check_eq("rst_ok", 32'(bus.frame_ok), 0);
                check_eq("rst_err", 32'(bus.frame_err), 0);
                check_eq("rst_state", 32'(bus.rx_state), 0);
            end
            rst = (i == rst_at);
            bus.datain = frm[i];
            bus.rxer = (i == er_at);
            bus.fifo_full = (full_at >= 0 && i >= full_at);
            last_state = bus.rx_state;
        end
        @(posedge clk); #1;
        bus.rxdv = 1'b0; bus.rxer = 1'b0; bus.fifo_full = 1'b0; bus.datain = 8'h00; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        ok_now = bus.frame_ok;
        err_now = bus.frame_err;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.rxdv = 1'b0; bus.rxer = 1'b0; bus.datain = 8'h00; bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_wr_en", 32'(bus.fifo_wr_en), 0);
        check_eq("reset_dataout", 32'(bus.dataout), 0);
        check_eq("reset_len", 32'(bus.rx_data_length), 0);
        check_eq("reset_ok", 32'(bus.frame_ok), 0);
        check_eq("reset_err", 32'(bus.frame_err), 0);
        check_eq("reset_state", 32'(bus.rx_state), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Unicast, 1000-byte payload
        build(MAC_OK, 16'h0800, IP_OK, 16'd1008, 0, 1'b0, 8'h3C, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("uni_writes", 32'(wr_cnt - w0), 1000);
        check_eq("uni_data", 32'(bad_cnt - b0), 0);
        check_eq("uni_len", 32'(bus.rx_data_length), 1000);
        check_eq("uni_ok_timing", 32'(ok_now), 1);
        check_eq("uni_ok_cnt", 32'(ok_cnt - o0), 1);
        check_eq("uni_err_cnt", 32'(err_cnt - e0), 0);
        check_eq("uni_state_end", 32'(bus.rx_state), 0);

        // Same frame with one payload bit flipped
        build(MAC_OK, 16'h0800, IP_OK, 16'd1008, 0, 1'b0, 8'h3C, 500);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("flip_writes", 32'(wr_cnt - w0), 1000);
        check_eq("flip_data", 32'(bad_cnt - b0), 0);
        check_eq("flip_err_timing", 32'(err_now), 1);
        check_eq("flip_ok_cnt", 32'(ok_cnt - o0), 0);
        check_eq("flip_err_cnt", 32'(err_cnt - e0), 1);

        // Broadcast, 4-byte payload plus 14 bytes of padding
        build(MAC_BC, 16'h0800, IP_OK, 16'd12, 14, 1'b0, 8'hA5, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("bc_writes", 32'(wr_cnt - w0), 4);
        check_eq("bc_data", 32'(bad_cnt - b0), 0);
        check_eq("bc_len", 32'(bus.rx_data_length), 4);
        check_eq("bc_ok_cnt", 32'(ok_cnt - o0), 1);

        // Wrong destination IP: dropped silently
        build(MAC_OK, 16'h0800, IP_BAD, 16'd40, 0, 1'b0, 8'h11, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("ip_writes", 32'(wr_cnt - w0), 0);
        check_eq("ip_pulses", 32'(ok_cnt - o0 + err_cnt - e0), 0);
        check_eq("ip_drop_state", 32'(last_state), 7);
        check_eq("ip_idle_after", 32'(bus.rx_state), 0);
        check_eq("ip_len_held", 32'(bus.rx_data_length), 4);

        // ARP EtherType: dropped silently
        build(MAC_OK, 16'h0806, IP_OK, 16'd40, 0, 1'b0, 8'h22, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("arp_writes", 32'(wr_cnt - w0), 0);
        check_eq("arp_pulses", 32'(ok_cnt - o0 + err_cnt - e0), 0);
        check_eq("arp_drop_state", 32'(last_state), 7);

        // FIFO full after 10th payload byte
        build(MAC_OK, 16'h0800, IP_OK, 16'd108, 0, 1'b0, 8'h5A, -1);
        mark(); send(PAY_IDX + 10, -1, -1, -1); idle(4);
        check_eq("full_writes", 32'(wr_cnt - w0), 10);
        check_eq("full_data", 32'(bad_cnt - b0), 0);
        check_eq("full_err_cnt", 32'(err_cnt - e0), 1);
        check_eq("full_ok_cnt", 32'(ok_cnt - o0), 0);

        // Reset mid-DATA, rest of frame ignored
        build(MAC_OK, 16'h0800, IP_OK, 16'd108, 0, 1'b0, 8'h77, -1);
        mark(); send(-1, PAY_IDX + 20, -1, -1); idle(4);
        check_eq("rstf_writes", 32'(wr_cnt - w0), 20);
        check_eq("rstf_data", 32'(bad_cnt - b0), 0);
        check_eq("rstf_pulses", 32'(ok_cnt - o0 + err_cnt - e0), 0);
        build(MAC_OK, 16'h0800, IP_OK, 16'd20, 0, 1'b0, 8'h19, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("post_rst_ok", 32'(ok_cnt - o0), 1);
        check_eq("post_rst_writes", 32'(wr_cnt - w0), 12);

        // Truncated inside DATA
        build(MAC_OK, 16'h0800, IP_OK, 16'd108, 0, 1'b0, 8'h44, -1);
        mark(); send(-1, -1, PAY_IDX + 5, -1); idle(4);
        check_eq("trunc_writes", 32'(wr_cnt - w0), 5);
        check_eq("trunc_err_cnt", 32'(err_cnt - e0), 1);
        check_eq("trunc_ok_cnt", 32'(ok_cnt - o0), 0);

        // rxer inside the payload: all bytes still written, frame fails
        build(MAC_OK, 16'h0800, IP_OK, 16'd108, 0, 1'b0, 8'h66, -1);
        mark(); send(-1, -1, -1, PAY_IDX + 3); idle(4);
        check_eq("rxer_writes", 32'(wr_cnt - w0), 100);
        check_eq("rxer_err_cnt", 32'(err_cnt - e0), 1);
        check_eq("rxer_ok_cnt", 32'(ok_cnt - o0), 0);

        // Zero-length UDP payload with padding
        build(MAC_OK, 16'h0800, IP_OK, 16'd8, 18, 1'b0, 8'h00, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
        check_eq("zero_writes", 32'(wr_cnt - w0), 0);
        check_eq("zero_len", 32'(bus.rx_data_length), 0);
        check_eq("zero_ok_cnt", 32'(ok_cnt - o0), 1);

        // Back-to-back frames with a single idle cycle
        build(MAC_OK, 16'h0800, IP_OK, 16'd20, 0, 1'b0, 8'h31, -1);
        mark(); w_all = wr_cnt; send(-1, -1, -1, -1);
        build(MAC_OK, 16'h0800, IP_OK, 16'd24, 0, 1'b0, 8'h93, -1);
        wr_base = wr_cnt; b0 = bad_cnt;
        send(-1, -1, -1, -1); idle(4);
        check_eq("b2b_ok_overlap", 32'(ok_at_start), 1);
        check_eq("b2b_ok_cnt", 32'(ok_cnt - o0), 2);
        check_eq("b2b_writes", 32'(wr_cnt - w_all), 28);
        check_eq("b2b_data", 32'(bad_cnt - b0), 0);

        // Corrupted IP header checksum
        build(MAC_OK, 16'h0800, IP_OK, 16'd12, 14, 1'b1, 8'h58, -1);
        mark(); send(-1, -1, -1, -1); idle(4);
`ifdef RX_IP_CSUM_CHECK_EN
        check_eq("csum_writes", 32'(wr_cnt - w0), 0);
        check_eq("csum_pulses", 32'(ok_cnt - o0 + err_cnt - e0), 0);
        check_eq("csum_drop_state", 32'(last_state), 7);
`else
        check_eq("csum_writes", 32'(wr_cnt - w0), 4);
        check_eq("csum_ok_cnt", 32'(ok_cnt - o0), 1);
        check_eq("csum_err_cnt", 32'(err_cnt - e0), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
